// File: rtl/r_burst_sender_if.sv
// rtl/r_burst_sender_if.sv - command, source and R-channel bundle for r_burst_sender
// The master modport is the beat sender; the slave modport is its surrounding environment.
interface r_burst_sender_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int LEN_WIDTH  = 8
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  cmd_err;
  logic                  src_valid;
  logic                  src_ready;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  r_valid;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [RESP_WIDTH-1:0] r_resp;
  logic                  r_last;
  logic                  r_ready;

  modport master (
    input  cmd_valid, cmd_id, cmd_len, cmd_err,
    output cmd_ready,
    input  src_valid, src_data,
    output src_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );

  modport slave (
    output cmd_valid, cmd_id, cmd_len, cmd_err,
    input  cmd_ready,
    output src_valid, src_data,
    input  src_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );
endinterface

// File: rtl/r_burst_sender.sv
// rtl/r_burst_sender.sv - AXI read-data channel sender: one command in, len+1 R beats out
// A single output register stage; a new beat loads whenever the stage is empty or draining.
module r_burst_sender #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  r_burst_sender_if.master bus
);
  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [LEN_WIDTH:0]    ONE         = (LEN_WIDTH+1)'(1);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err_q;
  logic [LEN_WIDTH:0]    remaining;
  logic                  r_valid_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [RESP_WIDTH-1:0] r_resp_q;
  logic                  r_last_q;
  logic                  load;

  // Error bursts never wait for the source, so they load on backpressure alone.
  assign load = (state == BURST) && (remaining != '0) &&
                (!r_valid_q || bus.r_ready) && (err_q || bus.src_valid);

  assign bus.cmd_ready = (state == IDLE);
  assign bus.src_ready = load && !err_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_id      = r_id_q;
  assign bus.r_data    = r_data_q;
  assign bus.r_resp    = r_resp_q;
  assign bus.r_last    = r_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      id_q      <= '0;
      err_q     <= 1'b0;
      remaining <= '0;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            id_q      <= bus.cmd_id;
            err_q     <= bus.cmd_err;
            remaining <= {1'b0, bus.cmd_len} + ONE;
            state     <= BURST;
          end
        end
        BURST: begin
          if (load) begin
            r_valid_q <= 1'b1;
            r_id_q    <= id_q;
            r_data_q  <= err_q ? '0 : bus.src_data;
            r_resp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
            r_last_q  <= (remaining == ONE);
            remaining <= remaining - ONE;
          end else if (r_valid_q && bus.r_ready) begin
            // remaining is zero once the last beat is out, so this path ends the burst.
            r_valid_q <= 1'b0;
            if (r_last_q) begin
              r_last_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_r_burst_sender.sv
// tb/tb_r_burst_sender.sv - directed burst table plus reset corner sequence for r_burst_sender
module tb_r_burst_sender;
  logic clk;
  logic rst_n;

  r_burst_sender_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .LEN_WIDTH(8)) bus ();

  r_burst_sender #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .LEN_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // src_mode: 0 always valid, 1 valid on odd cycles, 2 never valid
  // rdy_mode: 0 always ready, 1 r_ready low for 3 cycles while beat 2 is shown
  typedef struct {
    logic [3:0]  id;
    logic [7:0]  len;
    logic        err;
    logic [63:0] base;
    int          src_mode;
    int          rdy_mode;
    int          exp_beats;
    int          exp_srdy;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[6];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int          beats, srdy, first_cyc, last_cyc, stall_cnt;
    bit          got_last, prev_stall, done;
    logic [127:0] snap, cur;
    beats = 0; srdy = 0; first_cyc = -1; last_cyc = -1; stall_cnt = 0;
    got_last = 0; prev_stall = 0; done = 0; snap = '0;

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_id    = v.id;
    bus.cmd_len   = v.len;
    bus.cmd_err   = v.err;
    bus.src_valid = 1'b0;
    bus.r_ready   = 1'b1;
    #1;
    check("cmd_ready_idle", 128'(bus.cmd_ready), 128'(1));

    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      // Keep offering a different command mid-burst; it must be ignored.
      bus.cmd_valid = !got_last;
      bus.cmd_id    = ~v.id;
      bus.cmd_len   = 8'h00;
      bus.cmd_err   = ~v.err;
      case (v.src_mode)
        0:       bus.src_valid = 1'b1;
        1:       bus.src_valid = (cyc % 2) == 1;
        default: bus.src_valid = 1'b0;
      endcase
      bus.src_data = v.base + 64'(srdy);
      bus.r_ready  = 1'b1;
      if (v.rdy_mode == 1 && bus.r_valid && beats == 1 && stall_cnt < 3) begin
        bus.r_ready = 1'b0;
        stall_cnt++;
      end
      #1;
      if (got_last) begin
        check("cmd_ready_after_last", 128'(bus.cmd_ready), 128'(1));
        done = 1;
        break;
      end
      cur = 128'({bus.r_valid, bus.r_id, bus.r_data, bus.r_resp, bus.r_last});
      if (prev_stall) check("hold_stable", cur, snap);
      prev_stall = bus.r_valid && !bus.r_ready;
      if (prev_stall) begin
        check("no_pop_stall", 128'(bus.src_ready), 128'(0));
        snap = cur;
      end
      if (bus.src_ready) srdy++;
      if (bus.r_valid && bus.r_ready) begin
        check("beat_id",   128'(bus.r_id),   128'(v.id));
        check("beat_data", 128'(bus.r_data), v.err ? 128'(0) : 128'(v.base + 64'(beats)));
        check("beat_resp", 128'(bus.r_resp), 128'(v.exp_resp));
        check("beat_last", 128'(bus.r_last), 128'(beats == int'(v.len)));
        if (beats == 0) first_cyc = cyc;
        beats++;
        if (bus.r_last) begin
          check("cmd_ready_during_last", 128'(bus.cmd_ready), 128'(0));
          got_last = 1;
          last_cyc = cyc;
        end
      end
    end

    check("burst_done", 128'(done), 128'(1));
    check("beat_count", 128'(beats), 128'(v.exp_beats));
    check("src_ready_count", 128'(srdy), 128'(v.exp_srdy));
    if (v.src_mode != 1) check("first_beat_latency", 128'(first_cyc), 128'(2));
    if (v.src_mode != 1 && v.rdy_mode == 0)
      check("back_to_back", 128'(last_cyc - first_cyc), 128'(v.len));
    bus.cmd_valid = 1'b0;
  endtask

  task automatic reset_mid_burst();
    int  hs;
    bit  hit;
    hs = 0; hit = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_id    = 4'd4;
    bus.cmd_len   = 8'd3;
    bus.cmd_err   = 1'b0;
    bus.src_valid = 1'b1;
    bus.src_data  = 64'h10;
    bus.r_ready   = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.src_data  = 64'h10 + 64'(cyc);
      #1;
      if (bus.r_valid && hs == 1) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              128'({bus.r_valid, bus.r_id, bus.r_data, bus.r_resp, bus.r_last}), 128'(0));
        check("rst_mid_src_ready", 128'(bus.src_ready), 128'(0));
        check("rst_mid_cmd_ready", 128'(bus.cmd_ready), 128'(1));
        hit = 1;
        break;
      end
      if (bus.r_valid && bus.r_ready) hs++;
    end
    check("rst_mid_reached", 128'(hit), 128'(1));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Source still offering data after release: nothing may be popped or emitted.
    @(negedge clk);
    #1;
    check("post_rst_no_pop", 128'({bus.src_ready, bus.r_valid}), 128'(0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{id: 4'd3, len: 8'd0,   err: 1'b0, base: 64'hA5A5, src_mode: 0, rdy_mode: 0,
                exp_beats: 1,   exp_srdy: 1,   exp_resp: 2'b00};
    vecs[1] = '{id: 4'd5, len: 8'd3,   err: 1'b0, base: 64'd1,    src_mode: 0, rdy_mode: 0,
                exp_beats: 4,   exp_srdy: 4,   exp_resp: 2'b00};
    vecs[2] = '{id: 4'd2, len: 8'd2,   err: 1'b0, base: 64'd1,    src_mode: 0, rdy_mode: 1,
                exp_beats: 3,   exp_srdy: 3,   exp_resp: 2'b00};
    vecs[3] = '{id: 4'd7, len: 8'd1,   err: 1'b1, base: 64'd0,    src_mode: 2, rdy_mode: 0,
                exp_beats: 2,   exp_srdy: 0,   exp_resp: 2'b10};
    vecs[4] = '{id: 4'd9, len: 8'd255, err: 1'b0, base: 64'h1000, src_mode: 1, rdy_mode: 0,
                exp_beats: 256, exp_srdy: 256, exp_resp: 2'b00};
    vecs[5] = '{id: 4'd1, len: 8'd0,   err: 1'b0, base: 64'h77,   src_mode: 0, rdy_mode: 0,
                exp_beats: 1,   exp_srdy: 1,   exp_resp: 2'b00};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_id    = '0;
    bus.cmd_len   = '0;
    bus.cmd_err   = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    bus.r_ready   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          128'({bus.r_valid, bus.r_id, bus.r_data, bus.r_resp, bus.r_last}), 128'(0));
    check("reset_cmd_ready", 128'(bus.cmd_ready), 128'(1));
    check("reset_src_ready", 128'(bus.src_ready), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);
    reset_mid_burst();
    run_burst(vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/r_burst_sender.md
Name: r_burst_sender

Overview:
- Slave-side AXI read-data channel driver: the sending end of the R channel whose receiver is the ROB/master side.
- Accepts one read command at a time (id, burst length, error flag) and pops data words from an upstream source queue.
- Emits one R beat per data word, with the ID, response code and LAST flag, and obeys valid/ready backpressure.
- Sits between the memory/source model and the ROB's R input in the bench and in the system.

Parameters:
- ID_WIDTH, 4, width of the transaction ID.
- DATA_WIDTH, 64, width of the data bus.
- RESP_WIDTH, 2, width of the response field.
- LEN_WIDTH, 8, width of the burst length field (AXI LEN encoding: beats minus 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_id  in  ID_WIDTH  transaction ID for every beat of the burst.
- cmd_len  in  LEN_WIDTH  beats minus 1 (0 means 1 beat).
- cmd_err  in  1  1 means the burst returns SLVERR and consumes no source data.
- src_valid  in  1  source data word available.
- src_ready  out  1  source word consumed this cycle.
- src_data  in  DATA_WIDTH  source data word.
- r_valid  out  1  R beat valid.
- r_id  out  ID_WIDTH  beat ID.
- r_data  out  DATA_WIDTH  beat data.
- r_resp  out  RESP_WIDTH  2'b00 OKAY or 2'b10 SLVERR.
- r_last  out  1  final beat of the burst.
- r_ready  in  1  receiver accepts the beat.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, r_valid=0, r_last=0, r_id=0, r_data=0, r_resp=0, beat counters=0. cmd_ready is high immediately after reset; src_ready is low.
- States:
  - IDLE: cmd_ready=1. A command handshake (cmd_valid&cmd_ready) latches id, len and err, sets remaining=len+1 (LEN_WIDTH+1 bits, so no overflow at len=255), then moves to BURST.
  - BURST: cmd_ready=0.
- Load condition: load = BURST && remaining!=0 && (!r_valid || r_ready) && (err || src_valid).
- Data path:
  - src_ready = load && !err. This is combinational, so the source pops in the same cycle as load.
  - On load, the output register takes src_data with r_resp=OKAY; if err, it takes r_data=0 with r_resp=SLVERR.
  - On load, r_id takes the latched id, r_valid becomes 1, r_last becomes (remaining==1), and remaining decrements.
- Hold rule: while r_valid=1 and r_ready=0, all r_* outputs stay stable. There is no source pop.
- Drain rule: when r_valid&r_ready and no load happens in the same cycle, r_valid drops to 0 on the next edge.
- Back-to-back: simultaneous handshake and load gives full throughput of one beat per cycle.
- End of burst: a handshake with r_last=1 moves the state to IDLE; r_valid becomes 0 and cmd_ready becomes 1 on the next edge. A new command is never accepted in the same cycle the last beat completes.
- Latency: a command accepted at edge N makes the first beat visible after edge N+1, provided src_valid is high in the cycle after N.
- Source starvation: src_valid=0 mid-burst produces no beat. r_valid drops after the current beat drains; the burst resumes when data arrives. Beat order and count are preserved.
- SLVERR bursts still emit exactly len+1 beats, with r_last on the final one.
- Reset mid-burst: everything returns to reset values immediately. Partial bursts are discarded, with no further beats or pops.
- cmd_* is ignored outside IDLE.

Test Plan:
- Single beat: cmd id=3 len=0, src word 0xA5A5, r_ready=1 -> one beat id=3, data=0xA5A5, resp=00, last=1; cmd_ready high again 1 cycle later.
- 4-beat stream: id=5 len=3, src words 1..4 always valid, r_ready=1 -> 4 consecutive cycles of beats with data 1,2,3,4; last only on data 4; exactly 4 src pops.
- Backpressure: id=2 len=2, r_ready low for 3 cycles on beat 2 -> beat 2 outputs stable throughout, no src pop during the stall, final sequence 1,2,3 intact.
- Error burst: id=7 len=1 cmd_err=1, src_valid=0 -> 2 beats, resp=10, data=0, last on the second beat, src_ready never asserted.
- Starvation and max length: len=255 with src_valid toggling every other cycle -> exactly 256 beats, last on beat 256, no duplicates or drops.
- Reset mid-burst: rst_n low during beat 2 of a len=3 burst -> r_valid=0 immediately; after release, a new cmd id=1 len=0 completes normally.
